// File: rtl/seg7_scan_driver.sv
// Multiplexed N-digit seven-segment scan driver with hex decode,
// leading-zero blanking, 16-level duty and frame-synchronous updates.
module seg7_scan_driver #(
   parameter int unsigned NUM_DIGITS  = 4,
   parameter int unsigned SLOT_CYCLES = 100000,
   parameter bit          ACTIVE_LOW  = 1'b1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [4*NUM_DIGITS-1:0]   digits,
   input  logic [NUM_DIGITS-1:0]     dp,
   input  logic                      load,
   input  logic                      enable,
   input  logic                      blank_lz,
   input  logic [3:0]                brightness,
   output logic [NUM_DIGITS-1:0]     AN,
   output logic [7:0]                Cathode,
   output logic                      frame_start
);

   localparam int unsigned CW   = $clog2(SLOT_CYCLES);
   localparam int unsigned IW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int unsigned STEP = SLOT_CYCLES / 16;

   localparam logic [CW:0]   STEP_W  = (CW+1)'(STEP);
   localparam logic [CW-1:0] SLOT_TC = CW'(SLOT_CYCLES - 1);
   localparam logic [IW-1:0] IDX_TC  = IW'(NUM_DIGITS - 1);

   localparam logic [NUM_DIGITS-1:0] AN_OFF  = ACTIVE_LOW ? '1 : '0;
   localparam logic [7:0]            CAT_OFF = ACTIVE_LOW ? 8'hFF : 8'h00;

   logic [CW-1:0]           slot_cnt;
   logic [IW-1:0]           scan_idx;
   logic [4*NUM_DIGITS-1:0] act_digits;
   logic [NUM_DIGITS-1:0]   act_dp;
   logic [4*NUM_DIGITS-1:0] pend_digits;
   logic [NUM_DIGITS-1:0]   pend_dp;
   logic                    pend_flag;

   logic                    slot_tc;
   logic                    wrap;
   logic [CW:0]             thresh;
   logic                    duty_on;
   logic [NUM_DIGITS-1:0]   blank;
   logic                    zero_run;
   logic [3:0]              cur_nib;
   logic                    lit;
   logic [NUM_DIGITS-1:0]   an_hi;
   logic [7:0]              cat_hi;

   function automatic logic [6:0] hex_seg(input logic [3:0] n);
      case (n)
         4'h0:    hex_seg = 7'h3F;
         4'h1:    hex_seg = 7'h06;
         4'h2:    hex_seg = 7'h5B;
         4'h3:    hex_seg = 7'h4F;
         4'h4:    hex_seg = 7'h66;
         4'h5:    hex_seg = 7'h6D;
         4'h6:    hex_seg = 7'h7D;
         4'h7:    hex_seg = 7'h07;
         4'h8:    hex_seg = 7'h7F;
         4'h9:    hex_seg = 7'h6F;
         4'hA:    hex_seg = 7'h77;
         4'hB:    hex_seg = 7'h7C;
         4'hC:    hex_seg = 7'h39;
         4'hD:    hex_seg = 7'h5E;
         4'hE:    hex_seg = 7'h79;
         default: hex_seg = 7'h71;
      endcase
   endfunction

   assign slot_tc = (slot_cnt == SLOT_TC);
   assign wrap    = slot_tc && (scan_idx == IDX_TC);

   // Threshold reaches SLOT_CYCLES at brightness 15, hence one extra bit.
   assign thresh  = ({{(CW-3){1'b0}}, brightness} + (CW+1)'(1)) * STEP_W;
   assign duty_on = ({1'b0, slot_cnt} < thresh);

   always_comb begin
      blank    = '0;
      zero_run = blank_lz;
      for (int i = NUM_DIGITS - 1; i > 0; i--) begin
         zero_run = zero_run && (act_digits[4*i +: 4] == 4'h0) && !act_dp[i];
         blank[i] = zero_run;
      end
   end

   always_comb begin
      cur_nib = act_digits[{scan_idx, 2'b00} +: 4];
      lit     = enable && !blank[scan_idx] && duty_on;
      an_hi   = '0;
      cat_hi  = 8'h00;
      if (lit) begin
         an_hi[scan_idx] = 1'b1;
         cat_hi          = {act_dp[scan_idx], hex_seg(cur_nib)};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         slot_cnt <= '0;
         scan_idx <= '0;
      end else begin
         slot_cnt <= slot_tc ? '0 : slot_cnt + CW'(1);
         if (slot_tc)
            scan_idx <= wrap ? '0 : scan_idx + IW'(1);
      end
   end

   // Active buffer only moves at the wrap so a frame never mixes values.
   always_ff @(posedge clk) begin
      if (reset) begin
         act_digits  <= '0;
         act_dp      <= '0;
         pend_digits <= '0;
         pend_dp     <= '0;
         pend_flag   <= 1'b0;
      end else begin
         if (wrap && pend_flag) begin
            act_digits <= pend_digits;
            act_dp     <= pend_dp;
         end
         if (load) begin
            pend_digits <= digits;
            pend_dp     <= dp;
            pend_flag   <= 1'b1;
         end else if (wrap) begin
            pend_flag <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         AN          <= AN_OFF;
         Cathode     <= CAT_OFF;
         frame_start <= 1'b0;
      end else begin
         AN          <= ACTIVE_LOW ? ~an_hi : an_hi;
         Cathode     <= ACTIVE_LOW ? ~cat_hi : cat_hi;
         frame_start <= wrap;
      end
   end

endmodule
